blt_scanline_addr_gen: RTL and testbench

Parametrised bullet-sprite address generator for the VGA pixel path. It sits between the bullet state registers and the bullet sprite ROM. During each line's horizontal blanking it scans all bullets once and latches up to `SLOTS` bullets that intersect the next line. During the active line it emits a registered ROM address, hit flag and winning bullet index per pixel. Overlaps resolve by lowest bullet index rather than by OR-ing addresses. Bullets beyond `SLOTS` on one line are counted as drops, not merged.

---
 rtl/blt_scanline_addr_gen.sv | 191 +++++++++++++++++++
 tb/tb_blt_scanline_addr_gen.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/blt_scanline_addr_gen.sv
// blt_scanline_addr_gen
//   Bullet-sprite address generator for the VGA pixel path. During horizontal blanking it
//   scans every bullet once (one per clock) and latches up to SLOTS bullets that cover the
//   next line. During the following line it emits, one cycle after each h_cnt, the sprite ROM
//   address, hit flag and index of the lowest-indexed bullet covering that pixel.
// Ports
//   clk, rst         pixel clock, synchronous active-high reset
//   blt_vi/x/y       per-bullet visible flag and packed coordinates
//   h_cnt, v_cnt     current pixel column and line
//   blt_addr/hit/idx registered pixel result (all zero when no bullet covers the pixel)
//   scan_busy        high while the per-line scan or its commit is in progress
//   drop_cnt         saturating per-frame count of bullets that found no free slot
module blt_scanline_addr_gen #(
   parameter int unsigned N_BLT      = 13,
   parameter int unsigned COORD_W    = 9,
   parameter int unsigned SPR_W      = 15,
   parameter int unsigned SPR_H      = 15,
   parameter int unsigned MEM_W      = 30,
   parameter int unsigned X_OFS      = 160,
   parameter int unsigned ADDR_W     = 17,
   parameter int unsigned SLOTS      = 4,
   parameter int unsigned SCAN_START = 640,
   parameter int unsigned V_TOTAL    = 525,
   localparam int unsigned IDX_W     = $clog2(N_BLT)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_BLT-1:0]           blt_vi,
   input  logic [N_BLT*COORD_W-1:0]   blt_x,
   input  logic [N_BLT*COORD_W-1:0]   blt_y,
   input  logic [9:0]                 h_cnt,
   input  logic [9:0]                 v_cnt,
   output logic [ADDR_W-1:0]          blt_addr,
   output logic                       blt_hit,
   output logic [IDX_W-1:0]           blt_idx,
   output logic                       scan_busy,
   output logic [7:0]                 drop_cnt
);

   localparam int unsigned ROW_W  = $clog2(SPR_H);
   localparam int unsigned FILL_W = $clog2(SLOTS + 1);
   localparam int unsigned EXT_W  = COORD_W + 2;  // wide enough that y+SPR_H never wraps
   localparam int unsigned PX_W   = 11;

   typedef enum logic [1:0] {StIdle, StScan, StCommit} state_e;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [ROW_W-1:0]   row;
      logic [IDX_W-1:0]   idx;
   } slot_t;

   state_e              st_q, st_d;
   logic [IDX_W-1:0]    scan_idx_q, scan_idx_d;
   logic [9:0]          tl_q, tl_d;
   slot_t               pend_q [SLOTS];
   slot_t               pend_d [SLOTS];
   slot_t               act_q  [SLOTS];
   slot_t               act_d  [SLOTS];
   logic [FILL_W-1:0]   pend_fill_q, pend_fill_d;
   logic [FILL_W-1:0]   act_fill_q, act_fill_d;
   logic [7:0]          drop_q, drop_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                hit_q, hit_d;
   logic [IDX_W-1:0]    idx_q, idx_d;

   // Bullet currently under scan
   logic [COORD_W-1:0]  cur_x, cur_y;
   logic [EXT_W-1:0]    y_ext, tl_ext;
   logic                cur_qual;

   always_comb begin
      cur_x    = blt_x[scan_idx_q*COORD_W +: COORD_W];
      cur_y    = blt_y[scan_idx_q*COORD_W +: COORD_W];
      y_ext    = EXT_W'(cur_y);
      tl_ext   = EXT_W'(tl_q);
      cur_qual = blt_vi[scan_idx_q] && (y_ext <= tl_ext) && (tl_ext < y_ext + EXT_W'(SPR_H));
   end

   // Scan FSM and slot bookkeeping
   always_comb begin
      st_d        = st_q;
      scan_idx_d  = scan_idx_q;
      tl_d        = tl_q;
      pend_d      = pend_q;
      pend_fill_d = pend_fill_q;
      act_d       = act_q;
      act_fill_d  = act_fill_q;
      drop_d      = drop_q;
      case (st_q)
         StIdle: begin
            if (h_cnt == 10'(SCAN_START)) begin
               st_d        = StScan;
               scan_idx_d  = '0;
               pend_fill_d = '0;
               pend_d      = '{default: '0};
               tl_d        = (v_cnt == 10'(V_TOTAL - 1)) ? 10'd0 : v_cnt + 10'd1;
               // Scan for line 0 marks the start of a new frame
               if (tl_d == 10'd0) drop_d = 8'd0;
            end
         end
         StScan: begin
            if (cur_qual) begin
               if (pend_fill_q < FILL_W'(SLOTS)) begin
                  for (int s = 0; s < SLOTS; s++) begin
                     if (FILL_W'(s) == pend_fill_q) begin
                        pend_d[s].x   = cur_x;
                        pend_d[s].row = ROW_W'(tl_ext - y_ext);
                        pend_d[s].idx = scan_idx_q;
                     end
                  end
                  pend_fill_d = pend_fill_q + FILL_W'(1);
               end else if (drop_q != 8'hFF) begin
                  drop_d = drop_q + 8'd1;
               end
            end
            if (scan_idx_q == IDX_W'(N_BLT - 1)) st_d = StCommit;
            else scan_idx_d = scan_idx_q + IDX_W'(1);
         end
         StCommit: begin
            act_d      = pend_q;
            act_fill_d = pend_fill_q;
            st_d       = StIdle;
         end
         default: st_d = StIdle;
      endcase
   end

   // Pixel stage: per-slot horizontal coverage, then lowest-slot priority
   logic [PX_W-1:0] h_ext;
   logic [PX_W-1:0] slot_lo [SLOTS];
   logic            slot_hit [SLOTS];

   always_comb begin
      h_ext = PX_W'(h_cnt);
      for (int s = 0; s < SLOTS; s++) begin
         slot_lo[s]  = PX_W'(act_q[s].x) + PX_W'(X_OFS);
         slot_hit[s] = (FILL_W'(s) < act_fill_q) && (h_ext >= slot_lo[s]) &&
                       (h_ext < slot_lo[s] + PX_W'(SPR_W));
      end
   end

   always_comb begin
      addr_d = '0;
      hit_d  = 1'b0;
      idx_d  = '0;
      for (int s = SLOTS - 1; s >= 0; s--) begin
         // Descending walk so the lowest hitting slot is written last and wins
         if (slot_hit[s]) begin
            hit_d  = 1'b1;
            idx_d  = act_q[s].idx;
            addr_d = ADDR_W'(act_q[s].row) * ADDR_W'(MEM_W) + ADDR_W'(h_ext - slot_lo[s]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q        <= StIdle;
         scan_idx_q  <= '0;
         tl_q        <= '0;
         pend_q      <= '{default: '0};
         act_q       <= '{default: '0};
         pend_fill_q <= '0;
         act_fill_q  <= '0;
         drop_q      <= '0;
         addr_q      <= '0;
         hit_q       <= 1'b0;
         idx_q       <= '0;
      end else begin
         st_q        <= st_d;
         scan_idx_q  <= scan_idx_d;
         tl_q        <= tl_d;
         pend_q      <= pend_d;
         act_q       <= act_d;
         pend_fill_q <= pend_fill_d;
         act_fill_q  <= act_fill_d;
         drop_q      <= drop_d;
         addr_q      <= addr_d;
         hit_q       <= hit_d;
         idx_q       <= idx_d;
      end
   end

   assign blt_addr  = addr_q;
   assign blt_hit   = hit_q;
   assign blt_idx   = idx_q;
   assign scan_busy = (st_q != StIdle);
   assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_blt_scanline_addr_gen.sv
// Directed and randomized bench for blt_scanline_addr_gen. Expected values come from a
// line-level model: the bullets covering the target line, taken in index order, first four
// rendered and the rest counted as drops; pixels resolved by the first covering bullet.
module tb_blt_scanline_addr_gen;

   localparam int N = 13;
   localparam int CW = 9;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [N-1:0]      blt_vi = '0;
   logic [N*CW-1:0]   blt_x = '0;
   logic [N*CW-1:0]   blt_y = '0;
   logic [9:0]        h_cnt = '0;
   logic [9:0]        v_cnt = '0;
   logic [16:0]       blt_addr;
   logic              blt_hit;
   logic [3:0]        blt_idx;
   logic              scan_busy;
   logic [7:0]        drop_cnt;

   int checks = 0;
   int errors = 0;

   // Model state
   int  bx [N];
   int  by [N];
   bit  bv [N];
   int  act_id [$];
   int  act_x [$];
   int  act_row [$];
   int  exp_drop = 0;

   blt_scanline_addr_gen dut (
      .clk       (clk),
      .rst       (rst),
      .blt_vi    (blt_vi),
      .blt_x     (blt_x),
      .blt_y     (blt_y),
      .h_cnt     (h_cnt),
      .v_cnt     (v_cnt),
      .blt_addr  (blt_addr),
      .blt_hit   (blt_hit),
      .blt_idx   (blt_idx),
      .scan_busy (scan_busy),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_blt(input int i, input bit vis, input int x, input int y);
      bv[i] = vis;
      bx[i] = x;
      by[i] = y;
      blt_vi[i] = vis;
      blt_x[i*CW +: CW] = x[CW-1:0];
      blt_y[i*CW +: CW] = y[CW-1:0];
   endtask

   task automatic clear_all();
      for (int i = 0; i < N; i++) set_blt(i, 1'b0, 0, 0);
   endtask

   // Launch a scan on line v, walk it to completion and update the model's active set
   task automatic do_scan(input int v);
      int tl;
      int ids [$];
      int xs [$];
      int rows [$];
      tl = (v == 524) ? 0 : v + 1;
      if (tl == 0) exp_drop = 0;
      for (int i = 0; i < N; i++) begin
         if (bv[i] && by[i] <= tl && tl < by[i] + 15) begin
            if (ids.size() < 4) begin
               ids.push_back(i);
               xs.push_back(bx[i]);
               rows.push_back(tl - by[i]);
            end else if (exp_drop < 255) begin
               exp_drop++;
            end
         end
      end
      v_cnt = v[9:0];
      h_cnt = 10'd640;
      tick();
      chk("busy_launch", scan_busy, 1);
      for (int k = 1; k <= N; k++) begin
         // A second launch value mid-scan must be ignored
         h_cnt = (k == 3) ? 10'd640 : 10'(641 + k);
         tick();
         chk("busy_scan", scan_busy, 1);
      end
      h_cnt = 10'd700;
      tick();
      chk("busy_done", scan_busy, 0);
      chk("drop_cnt", drop_cnt, exp_drop);
      act_id = ids;
      act_x = xs;
      act_row = rows;
      v_cnt = 10'(tl);
   endtask

   task automatic px(input int h);
      longint e_addr;
      longint e_hit;
      longint e_idx;
      e_addr = 0;
      e_hit = 0;
      e_idx = 0;
      for (int j = 0; j < act_id.size(); j++) begin
         if (e_hit == 0 && h >= act_x[j] + 160 && h < act_x[j] + 175) begin
            e_hit = 1;
            e_idx = act_id[j];
            e_addr = act_row[j] * 30 + (h - act_x[j] - 160);
         end
      end
      h_cnt = h[9:0];
      tick();
      chk("px_addr", blt_addr, e_addr);
      chk("px_hit", blt_hit, e_hit);
      chk("px_idx", blt_idx, e_idx);
   endtask

   initial begin
      // Reset with arbitrary inputs
      blt_vi = N'($urandom);
      blt_x = {$urandom, $urandom, $urandom, $urandom};
      blt_y = {$urandom, $urandom, $urandom, $urandom};
      h_cnt = 10'($urandom);
      v_cnt = 10'($urandom);
      rst = 1'b1;
      repeat (3) tick();
      chk("rst_addr", blt_addr, 0);
      chk("rst_hit", blt_hit, 0);
      chk("rst_idx", blt_idx, 0);
      chk("rst_busy", scan_busy, 0);
      chk("rst_drop", drop_cnt, 0);
      h_cnt = 10'd0;
      v_cnt = 10'd0;
      clear_all();
      rst = 1'b0;
      // No prior scan: visible bullet must not render yet
      set_blt(0, 1'b1, 10, 0);
      px(175);
      px(170);

      // Single bullet
      clear_all();
      set_blt(0, 1'b1, 10, 20);
      do_scan(21);
      px(175);
      px(184);
      px(185);
      px(169);
      px(170);

      // Vertical edges and visibility
      clear_all();
      set_blt(1, 1'b1, 30, 100);
      do_scan(99);
      px(190);
      do_scan(113);
      px(192);
      do_scan(114);
      px(192);
      set_blt(1, 1'b0, 30, 100);
      do_scan(99);
      px(190);

      // Overlap priority
      clear_all();
      set_blt(5, 1'b1, 50, 40);
      set_blt(3, 1'b1, 50, 40);
      do_scan(39);
      px(215);
      px(224);

      // Overflow, accumulation and frame clear
      clear_all();
      for (int i = 0; i < 6; i++) set_blt(i, 1'b1, 20 * i, 60);
      do_scan(59);
      for (int i = 0; i < 6; i++) px(20 * i + 165);
      do_scan(60);
      do_scan(524);
      px(165);
      for (int i = 0; i < N; i++) set_blt(i, 1'b1, 20 * i, 60);
      for (int r = 0; r < 29; r++) do_scan(59);

      // Reset in the middle of a scan
      do_scan(524);
      clear_all();
      set_blt(0, 1'b1, 10, 20);
      do_scan(21);
      v_cnt = 10'd21;
      h_cnt = 10'd640;
      tick();
      for (int k = 1; k <= 6; k++) begin
         h_cnt = 10'(641 + k);
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      act_id.delete();
      act_x.delete();
      act_row.delete();
      exp_drop = 0;
      chk("midrst_busy", scan_busy, 0);
      chk("midrst_drop", drop_cnt, 0);
      px(175);
      do_scan(21);
      px(175);

      // Randomized lines
      for (int it = 0; it < 30; it++) begin
         int v;
         int tl;
         v = (it % 10 == 9) ? 524 : int'($urandom_range(0, 523));
         tl = (v == 524) ? 0 : v + 1;
         for (int i = 0; i < N; i++) begin
            int y;
            y = (tl >= 18) ? tl - int'($urandom_range(0, 18)) : int'($urandom_range(0, 18));
            if (y > 511) y = 511 - int'($urandom_range(0, 3));
            set_blt(i, bit'($urandom_range(0, 1)), int'($urandom_range(0, 479)), y);
         end
         do_scan(v);
         for (int j = 0; j < act_x.size(); j++) begin
            int h;
            h = act_x[j] + 160 + int'($urandom_range(0, 15));
            if (h < 640) px(h);
         end
         for (int n = 0; n < 10; n++) px(int'($urandom_range(0, 639)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
